// File: rtl/tdm_demux_pkg.sv
// Shared types and sizing for the 1:8 TDM demultiplexer.
package tdm_demux_pkg;
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = 3;
endpackage

// File: rtl/tdm_demux_1x8_demux_2.sv
// 1:2 write-enable demux; one node of the slot-decode tree.
module demux_2 (
    input  logic       en,
    input  logic       s,
    output logic [1:0] y
);
    assign y[0] = en & ~s;
    assign y[1] = en &  s;
endmodule

// File: rtl/tdm_demux_1x8.sv
// 1:8 time-division demultiplexer: slot words gathered in a shadow buffer, frame
// transferred atomically to y. Define TDM_DEMUX_SYNC_CHECK_EN to enable framing checks.
module tdm_demux_1x8
    import tdm_demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    input  logic                       frame_sync,
    output logic [NUM_SLOTS*WIDTH-1:0] y,
    output logic                       y_valid,
    output logic                       locked,
    output logic                       sync_err
);
    state_t                              state, state_next;
    logic [SLOT_W-1:0]                   slot, slot_next, wr_slot;
    logic                                wr_en;
    logic                                err_next;
    logic [1:0]                          lvl1;
    logic [3:0]                          lvl2;
    logic [NUM_SLOTS-1:0]                slot_en;
    logic [NUM_SLOTS-2:0][WIDTH-1:0]     shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HUNT;
            slot  <= '0;
        end else begin
            state <= state_next;
            slot  <= slot_next;
        end
    end

    always_comb begin
        state_next = state;
        slot_next  = slot;
        wr_en      = 1'b0;
        wr_slot    = slot;
        err_next   = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        wr_en      = 1'b1;
                        wr_slot    = '0;
                        slot_next  = SLOT_W'(1);
                        state_next = LOCKED;
                    end
                end
                default: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    if (frame_sync && slot != '0) begin
                        // Early sync restarts the frame; the partial one is abandoned.
                        err_next  = 1'b1;
                        wr_en     = 1'b1;
                        wr_slot   = '0;
                        slot_next = SLOT_W'(1);
                    end else if (!frame_sync && slot == '0) begin
                        err_next   = 1'b1;
                        state_next = HUNT;
                    end else begin
                        wr_en     = 1'b1;
                        slot_next = slot + SLOT_W'(1);
                    end
`else
                    wr_en     = 1'b1;
                    slot_next = slot + SLOT_W'(1);
`endif
                end
            endcase
        end
    end

    // Three-level decode: slot[2] at the root, slot[0] at the leaves.
    demux_2 u_root (.en(wr_en), .s(wr_slot[2]), .y(lvl1));

    for (genvar i = 0; i < 2; i++) begin : g_mid
        demux_2 u_mid (.en(lvl1[i]), .s(wr_slot[1]), .y(lvl2[2*i +: 2]));
    end

    for (genvar i = 0; i < 4; i++) begin : g_leaf
        demux_2 u_leaf (.en(lvl2[i]), .s(wr_slot[0]), .y(slot_en[2*i +: 2]));
    end

    // Slot 7 never lands in the shadow: it completes the frame straight into y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow   <= '0;
            y        <= '0;
            y_valid  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SLOTS-1; k++)
                if (slot_en[k]) shadow[k] <= din;
            if (slot_en[NUM_SLOTS-1]) y <= {din, shadow};
            y_valid  <= slot_en[NUM_SLOTS-1];
            sync_err <= err_next;
        end
    end

    assign locked = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Randomized and directed bench for tdm_demux_1x8 (WIDTH=4) against a frame-level model.
module tb_tdm_demux_1x8;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   din = '0;
    logic           din_valid = 1'b0;
    logic           frame_sync = 1'b0;
    logic [8*W-1:0] y;
    logic           y_valid, locked, sync_err;

    int vectors = 0;
    int fails   = 0;

    tdm_demux_1x8 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .y(y), .y_valid(y_valid),
        .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Frame-level reference: words collected into an array, frame published on the 8th.
    bit             m_locked;
    int             m_pos;
    logic [W-1:0]   m_frame [8];
    logic [8*W-1:0] m_y;
    bit             m_yv, m_err;

    task automatic m_take(input logic [W-1:0] w);
        m_frame[m_pos] = w;
        if (m_pos == 7) begin
            for (int k = 0; k < 8; k++) m_y[k*W +: W] = m_frame[k];
            m_yv  = 1'b1;
            m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked = 1'b0; m_pos = 0; m_y = '0; m_yv = 1'b0; m_err = 1'b0;
            for (int k = 0; k < 8; k++) m_frame[k] = '0;
        end else begin
            m_yv = 1'b0;
            m_err = 1'b0;
            if (din_valid) begin
                if (!m_locked) begin
                    if (frame_sync) begin
                        m_frame[0] = din; m_pos = 1; m_locked = 1'b1;
                    end
                end else begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                    if (frame_sync && m_pos != 0) begin
                        m_err = 1'b1; m_frame[0] = din; m_pos = 1;
                    end else if (!frame_sync && m_pos == 0) begin
                        m_err = 1'b1; m_locked = 1'b0;
                    end else begin
                        m_take(din);
                    end
`else
                    m_take(din);
`endif
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("y", y, m_y);
        chk("y_valid", 32'(y_valid), 32'(m_yv));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("sync_err", 32'(sync_err), 32'(m_err));
    end

    // Drives one valid word; returns 1 time unit after the sampling edge.
    task automatic send(input logic [W-1:0] w, input logic s);
        din = w; din_valid = 1'b1; frame_sync = s;
        @(posedge clk); #1;
        din_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        idle(2);
        #2 rst = 1'b0;
        idle(1);
    endtask

    logic [W-1:0] acq [8];
    initial begin
        acq[0] = 1; acq[1] = 0; acq[2] = 1; acq[3] = 1;
        acq[4] = 0; acq[5] = 0; acq[6] = 1; acq[7] = 0;
    end

    initial begin
        idle(2);
        chk("reset_y", y, 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);
        rst = 1'b0;
        idle(1);

        // Acquisition: unsynced words ignored, then one frame.
        repeat (3) send(W'($urandom_range(15)), 1'b0);
        chk("hunt_locked", 32'(locked), 32'h0);
        for (int k = 0; k < 8; k++) send(acq[k], k == 0);
        chk("acq_y", y, 32'h0100_1101);
        chk("acq_yv", 32'(y_valid), 32'h1);
        chk("acq_locked", 32'(locked), 32'h1);

        // Same frame with random gaps; y must hold until slot 7.
        for (int k = 0; k < 8; k++) begin
            idle($urandom_range(1, 5));
            chk("gap_hold", y, 32'h0100_1101);
            send(acq[k], k == 0);
        end
        chk("gap_y", y, 32'h0100_1101);
        chk("gap_yv", 32'(y_valid), 32'h1);

        // Back-to-back frames.
        for (int k = 0; k < 8; k++) send(W'(k), k == 0);
        chk("b2b_y0", y, 32'h7654_3210);
        for (int k = 0; k < 8; k++) send(W'(k + 8), k == 0);
        chk("b2b_y1", y, 32'hFEDC_BA98);
        for (int k = 0; k < 8; k++) send(W'(1), k == 0);
        chk("b2b_y2", y, 32'h1111_1111);

        // Sync arriving at slot 4.
        for (int k = 0; k < 4; k++) send(W'(k + 2), k == 0);
        send(W'(9), 1'b1);
        chk("resync_y_held", y, 32'h1111_1111);
        for (int k = 0; k < 7; k++) send(W'(k + 3), 1'b0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        chk("resync_y", y, 32'h9876_5439);
`else
        chk("resync_locked", 32'(locked), 32'h1);
`endif

        // Missing sync on the 9th word.
        do_reset();
        for (int k = 0; k < 8; k++) send(W'(15 - k), k == 0);
        chk("miss_y", y, 32'h89AB_CDEF);
        send(W'(3), 1'b0);
        repeat (3) send(W'(4), 1'b0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
        chk("miss_locked", 32'(locked), 32'h0);
`else
        chk("miss_locked", 32'(locked), 32'h1);
`endif

        // Random traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) != 0)
                send(W'($urandom_range(15)), $urandom_range(9) == 0);
            else
                idle(1);
        end

        // Asynchronous reset mid-frame.
        do_reset();
        send(W'(5), 1'b1);
        send(W'(10), 1'b0);
        for (int k = 2; k < 8; k++) send(W'(0), 1'b0);
        chk("pre_rst_y", y, 32'h0000_00A5);
        send(W'(7), 1'b1);
        send(W'(7), 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_y", y, 32'h0);
        chk("async_rst_locked", 32'(locked), 32'h0);
        chk("async_rst_yv", 32'(y_valid), 32'h0);
        idle(2);
        #2 rst = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
